// File: rtl/router_fifo.sv
// Router output buffer: tagged byte FIFO with packet-length tracking.
// Optional sticky overflow/underflow flags under `ifdef ROUTER_FIFO_ERR_EN.
module router_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  pkt_busy
`ifdef ROUTER_FIFO_ERR_EN
    ,
    output logic                  err_ovf,
    output logic                  err_udf
`endif
);

    localparam int CW = 7;

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   occ;
    logic [CW-1:0]         cnt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH:0]   rd_word;

    assign full     = (occ == ADDR_WIDTH'(0) + (ADDR_WIDTH+1)'(DEPTH));
    assign empty    = (occ == '0);
    assign pkt_busy = (cnt != '0);
    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;
    assign rd_word  = mem[rd_ptr];

    // Storage is not reset; a flush only moves the pointers.
    always_ff @(posedge clock) begin
        if (resetn && !soft_reset && wr_acc)
            mem[wr_ptr] <= {lfd_state, data_in};
    end

    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            cnt      <= '0;
            data_out <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= rd_word[DATA_WIDTH-1:0];
                // A header always reloads: payload length plus parity byte.
                if (rd_word[DATA_WIDTH])
                    cnt <= CW'(rd_word[DATA_WIDTH-1:2]) + CW'(1);
                else if (cnt != '0)
                    cnt <= cnt - 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef ROUTER_FIFO_ERR_EN
    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (write_enb && full)
                err_ovf <= 1'b1;
            if (read_enb && empty)
                err_udf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
// Define ROUTER_FIFO_ERR_EN to also exercise the error flags.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_busy;
`ifdef ROUTER_FIFO_ERR_EN
    logic       err_ovf;
    logic       err_udf;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clock = ~clock;

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
`ifdef ROUTER_FIFO_ERR_EN
        ,
        .err_ovf    (err_ovf),
        .err_udf    (err_udf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input logic tag);
        write_enb = 1'b1;
        lfd_state = tag;
        data_in   = b;
        tick();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] exp,
                      input logic busy);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        chk({tag, "_data"}, 32'(data_out), 32'(exp));
        chk({tag, "_busy"}, 32'(pkt_busy), 32'(busy));
    endtask

    initial begin
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        read_enb   = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_busy", 32'(pkt_busy), 32'd0);

        // Packet: header 0x0D gives counter 4 after header read.
        wr(8'h0D, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        wr(8'hA3, 1'b0);
        wr(8'h5F, 1'b0);
        chk("pkt_nempty", 32'(empty), 32'd0);
        rd("pkt_hdr", 8'h0D, 1'b1);
        rd("pkt_b1", 8'hA1, 1'b1);
        rd("pkt_b2", 8'hA2, 1'b1);
        rd("pkt_b3", 8'hA3, 1'b1);
        rd("pkt_par", 8'h5F, 1'b0);
        chk("pkt_empty", 32'(empty), 32'd1);

        // Read on empty leaves data_out alone.
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        chk("udf_hold", 32'(data_out), 32'h5F);
`ifdef ROUTER_FIFO_ERR_EN
        chk("udf_flag", 32'(err_udf), 32'd1);
        tick();
        chk("udf_sticky", 32'(err_udf), 32'd1);
        chk("ovf_clr", 32'(err_ovf), 32'd0);
`endif

        // Full and wrap.
        for (int i = 0; i < 16; i++) begin
            chk("fill_nfull", 32'(full), 32'd0);
            wr(8'(i), 1'b0);
        end
        chk("fill_full", 32'(full), 32'd1);
        wr(8'hFF, 1'b0);
        chk("drop_full", 32'(full), 32'd1);
`ifdef ROUTER_FIFO_ERR_EN
        chk("ovf_flag", 32'(err_ovf), 32'd1);
`endif
        for (int i = 0; i < 16; i++)
            rd("drain", 8'(i), 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 16; i++)
            wr(8'(8'h40 + i), 1'b0);
        chk("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++)
            rd("wrap", 8'(8'h40 + i), 1'b0);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous at full: read served, write dropped.
        for (int i = 0; i < 16; i++)
            wr(8'(8'h80 + i), 1'b0);
        write_enb = 1'b1;
        data_in   = 8'hEE;
        read_enb  = 1'b1;
        tick();
        write_enb = 1'b0;
        read_enb  = 1'b0;
        chk("sim_full_data", 32'(data_out), 32'h80);
        for (int i = 1; i < 16; i++)
            rd("sim_full_rest", 8'(8'h80 + i), 1'b0);
        chk("sim_full_empty", 32'(empty), 32'd1);

        // Simultaneous at empty: write stored, read ignored.
        write_enb = 1'b1;
        data_in   = 8'h77;
        read_enb  = 1'b1;
        tick();
        write_enb = 1'b0;
        read_enb  = 1'b0;
        chk("sim_empty_hold", 32'(data_out), 32'h8F);
        chk("sim_empty_occ", 32'(empty), 32'd0);
        rd("sim_empty_rd", 8'h77, 1'b0);
        chk("sim_empty_after", 32'(empty), 32'd1);

        // Soft reset mid-packet; header 0x10 loads counter 5.
        wr(8'h10, 1'b1);
        for (int i = 1; i <= 5; i++)
            wr(8'(i), 1'b0);
        rd("sr_hdr", 8'h10, 1'b1);
        rd("sr_b1", 8'h01, 1'b1);
        soft_reset = 1'b1;
        write_enb  = 1'b1;
        read_enb   = 1'b1;
        data_in    = 8'h99;
        tick();
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        chk("sr_empty", 32'(empty), 32'd1);
        chk("sr_data", 32'(data_out), 32'h00);
        chk("sr_busy", 32'(pkt_busy), 32'd0);
`ifdef ROUTER_FIFO_ERR_EN
        chk("sr_ovf", 32'(err_ovf), 32'd0);
        chk("sr_udf", 32'(err_udf), 32'd0);
`endif
        wr(8'h33, 1'b0);
        rd("sr_next", 8'h33, 1'b0);
        chk("sr_next_empty", 32'(empty), 32'd1);

        // Hard reset mid-packet discards the partial packet.
        wr(8'h21, 1'b1);
        wr(8'hB1, 1'b0);
        rd("hr_hdr", 8'h21, 1'b1);
        resetn = 1'b0;
        tick();
        chk("hr_empty", 32'(empty), 32'd1);
        chk("hr_busy", 32'(pkt_busy), 32'd0);
        chk("hr_data", 32'(data_out), 32'h00);
        resetn = 1'b1;
        wr(8'hC5, 1'b0);
        rd("hr_next", 8'hC5, 1'b0);
        chk("hr_next_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
